snow64_instr_fetch: RTL and testbench

- Front-end fetch unit that sits directly upstream of the instruction cache.
- Holds the program counter and issues single-outstanding read requests to the icache's req_read port.
- Buffers returned instructions, each with its PC, in a small FIFO that feeds decode.
- Handles control-flow redirects by flushing the FIFO and discarding any stale in-flight response.

---
 rtl/snow64_instr_fetch.sv | 135 +++++++++++++
 tb/tb_snow64_instr_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_instr_fetch.sv
// Instruction fetch front end: holds the PC, issues single-outstanding icache reads,
// and buffers {instr, pc} pairs in a small FIFO for decode. Redirects flush everything.
module snow64_instr_fetch #(
    parameter int unsigned            WIDTH__ADDR  = 64,
    parameter int unsigned            WIDTH__INSTR = 32,
    parameter int unsigned            FIFO_DEPTH   = 4,
    parameter logic [WIDTH__ADDR-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    out_icache_req,
    output logic [WIDTH__ADDR-1:0]  out_icache_addr,
    input  logic                    in_icache_valid,
    input  logic [WIDTH__INSTR-1:0] in_icache_instr,
    input  logic                    in_redirect_valid,
    input  logic [WIDTH__ADDR-1:0]  in_redirect_addr,
    input  logic                    in_decode_ready,
    output logic                    out_instr_valid,
    output logic [WIDTH__INSTR-1:0] out_instr,
    output logic [WIDTH__ADDR-1:0]  out_instr_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WIDTH__ADDR-1:0]  r_pc;
    logic [WIDTH__ADDR-1:0]  w_pc_next;
    logic [WIDTH__ADDR-1:0]  w_redirect_pc;

    logic [WIDTH__INSTR-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [WIDTH__ADDR-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_nonempty;
    logic                    w_push;
    logic                    w_pop;

    assign w_redirect_pc = in_redirect_addr & ~WIDTH__ADDR'(3);
    assign w_nonempty    = (r_count != '0);
    assign w_pop         = out_instr_valid && in_decode_ready;
    assign w_push        = (r_state == ST_WAIT) && in_icache_valid && !in_redirect_valid;
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign out_icache_req  = (r_state == ST_REQ);
    assign out_icache_addr = r_pc;
    assign out_instr_valid = w_nonempty && !in_redirect_valid;
    assign out_instr       = w_nonempty ? r_fifo_instr[r_rd_ptr] : '0;
    assign out_instr_pc    = w_nonempty ? r_fifo_pc[r_rd_ptr]    : '0;

    // Next-state and PC update; a redirect always reloads the PC.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (in_redirect_valid) begin
            w_pc_next = w_redirect_pc;
        end
        unique case (r_state)
            ST_IDLE: begin
                if (!in_redirect_valid && (w_count_next < CNT_W'(FIFO_DEPTH))) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_next = in_redirect_valid ? ST_DISCARD : ST_WAIT;
            end
            ST_WAIT: begin
                if (in_icache_valid) begin
                    w_state_next = ST_IDLE;
                    if (!in_redirect_valid) begin
                        w_pc_next = r_pc + WIDTH__ADDR'(4);
                    end
                end else if (in_redirect_valid) begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (in_icache_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Instruction FIFO; a redirect empties it at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[PTR_W'(i)] <= '0;
                r_fifo_pc[PTR_W'(i)]    <= '0;
            end
        end else if (in_redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= in_icache_instr;
                r_fifo_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Self-checking bench for snow64_instr_fetch: an icache responder with variable latency
// and a stream model (in-order pcs from the last redirect target, instr = f(pc)).
module tb_snow64_instr_fetch;

    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_icache_req;
    logic [63:0] out_icache_addr;
    logic        in_icache_valid = 1'b0;
    logic [31:0] in_icache_instr = '0;
    logic        in_redirect_valid = 1'b0;
    logic [63:0] in_redirect_addr = '0;
    logic        in_decode_ready = 1'b0;
    logic        out_instr_valid;
    logic [31:0] out_instr;
    logic [63:0] out_instr_pc;

    int          tests = 0;
    int          fails = 0;
    int          lat = 1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] exp_pc = RPC;
    logic [63:0] last_req = '0;
    logic [63:0] last_pop_pc = '0;
    int          nreq = 0;
    int          npop = 0;
    bit          ready = 1'b0;

    snow64_instr_fetch #(
        .WIDTH__ADDR (64),
        .WIDTH__INSTR(32),
        .FIFO_DEPTH  (4),
        .RESET_PC    (RPC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .out_icache_req   (out_icache_req),
        .out_icache_addr  (out_icache_addr),
        .in_icache_valid  (in_icache_valid),
        .in_icache_instr  (in_icache_instr),
        .in_redirect_valid(in_redirect_valid),
        .in_redirect_addr (in_redirect_addr),
        .in_decode_ready  (in_decode_ready),
        .out_instr_valid  (out_instr_valid),
        .out_instr        (out_instr),
        .out_instr_pc     (out_instr_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] icache_data(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5A5A5;
    endfunction

    // One cycle: icache responder, input drive, then stream checks on any pop.
    task automatic tick(input bit redir, input logic [63:0] raddr);
        bit          v;
        logic [63:0] va;
        @(posedge clk);
        #1;
        v  = 1'b0;
        va = pend_addr;
        if (pend) begin
            if (pend_cnt <= 0) begin
                v    = 1'b1;
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        in_icache_valid = v;
        in_icache_instr = v ? icache_data(va) : 32'($urandom);
        if (out_icache_req === 1'b1) begin
            tests++;
            if (out_icache_addr[1:0] !== 2'b00) begin
                fails++;
                $display("FAIL req_align: got %h want low bits 00", out_icache_addr);
            end
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_addr = out_icache_addr;
            last_req  = out_icache_addr;
            nreq++;
        end
        in_redirect_valid = redir;
        in_redirect_addr  = raddr;
        in_decode_ready   = ready;
        #1;
        if (redir) begin
            tests++;
            if (out_instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL redirect_gate: out_instr_valid got %b want 0", out_instr_valid);
            end
            exp_pc = raddr & ~64'h3;
        end else if (out_instr_valid === 1'b1 && ready) begin
            tests++;
            if (out_instr_pc !== exp_pc || out_instr !== icache_data(exp_pc)) begin
                fails++;
                $display("FAIL stream: got pc %h instr %h want pc %h instr %h",
                         out_instr_pc, out_instr, exp_pc, icache_data(exp_pc));
            end
            last_pop_pc = out_instr_pc;
            npop++;
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    task automatic wait_req(input int n, input int budget);
        int k = 0;
        while (nreq < n && k < budget) begin
            tick(1'b0, '0);
            k++;
        end
        tests++;
        if (nreq < n) begin
            fails++;
            $display("FAIL wait_req_timeout: got %0d requests want %0d", nreq, n);
        end
    endtask

    task automatic wait_pop(input int n, input int budget);
        int k = 0;
        while (npop < n && k < budget) begin
            tick(1'b0, '0);
            k++;
        end
        tests++;
        if (npop < n) begin
            fails++;
            $display("FAIL wait_pop_timeout: got %0d pops want %0d", npop, n);
        end
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        in_icache_valid   = 1'b0;
        in_redirect_valid = 1'b0;
        in_decode_ready   = 1'b0;
        pend              = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_pc = RPC;
        nreq   = 0;
        npop   = 0;
    endtask

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("reset_req", 64'(out_icache_req), 64'd0);
        check_eq("reset_addr", out_icache_addr, RPC);
        check_eq("reset_valid", 64'(out_instr_valid), 64'd0);
        check_eq("reset_instr", 64'(out_instr), 64'd0);
        check_eq("reset_pc", out_instr_pc, 64'd0);
    endtask

    task automatic test_stream();
        do_reset();
        ready = 1'b1;
        lat   = 1;
        wait_req(1, 5);
        check_eq("stream_first_req", last_req, RPC);
        repeat (40) tick(1'b0, '0);
        tests++;
        if (npop < 12 || npop > 14) begin
            fails++;
            $display("FAIL stream_rate: got %0d pops want 12..14", npop);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        lat   = 1;
        repeat (30) tick(1'b0, '0);
        check_eq("bp_req_count", 64'(nreq), 64'd4);
        check_eq("bp_req_low", 64'(out_icache_req), 64'd0);
        check_eq("bp_head_valid", 64'(out_instr_valid), 64'd1);
        check_eq("bp_head_pc", out_instr_pc, RPC);
        ready = 1'b1;
        tick(1'b0, '0);
        ready = 1'b0;
        check_eq("bp_one_pop", 64'(npop), 64'd1);
        wait_req(5, 10);
        check_eq("bp_next_req", last_req, RPC + 64'h10);
        repeat (10) tick(1'b0, '0);
        check_eq("bp_parked", 64'(nreq), 64'd5);
        ready = 1'b1;
        repeat (30) tick(1'b0, '0);
        tests++;
        if (npop < 6) begin
            fails++;
            $display("FAIL bp_drain: got %0d pops want >= 6", npop);
        end
    endtask

    task automatic test_redirect_wait();
        int saved;
        do_reset();
        ready = 1'b1;
        lat   = 4;
        wait_req(1, 10);
        tick(1'b1, 64'h2003);
        saved = npop;
        wait_req(2, 20);
        check_eq("rw_next_req", last_req, 64'h2000);
        check_eq("rw_no_stale_pop", 64'(npop), 64'(saved));
        wait_pop(saved + 1, 20);
        check_eq("rw_first_pc", last_pop_pc, 64'h2000);
    endtask

    task automatic test_redirect_same_cycle();
        int saved;
        do_reset();
        ready = 1'b0;
        lat   = 1;
        wait_req(2, 20);
        tick(1'b1, 64'h3000);
        ready = 1'b1;
        saved = npop;
        wait_req(3, 20);
        check_eq("rs_next_req", last_req, 64'h3000);
        wait_pop(saved + 1, 20);
        check_eq("rs_first_pc", last_pop_pc, 64'h3000);
    endtask

    task automatic test_wrap();
        int k = 0;
        int n;
        int saved;
        do_reset();
        ready = 1'b1;
        lat   = 1;
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        while (last_req !== 64'hFFFF_FFFF_FFFF_FFFC && k < 20) begin
            tick(1'b0, '0);
            k++;
        end
        check_eq("wrap_req", last_req, 64'hFFFF_FFFF_FFFF_FFFC);
        n     = nreq;
        saved = npop;
        wait_req(n + 1, 20);
        check_eq("wrap_next_req", last_req, 64'd0);
        check_eq("wrap_pop_count", 64'(npop), 64'(saved + 1));
        check_eq("wrap_pop_pc", last_pop_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1;
        lat   = 5;
        wait_req(1, 10);
        tick(1'b0, '0);
        rst = 1'b1;
        #1;
        check_eq("rm_req_low", 64'(out_icache_req), 64'd0);
        check_eq("rm_addr", out_icache_addr, RPC);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        pend            = 1'b0;
        in_icache_valid = 1'b1;
        in_icache_instr = 32'hDEADBEEF;
        exp_pc          = RPC;
        nreq            = 0;
        npop            = 0;
        lat             = 1;
        wait_req(1, 10);
        check_eq("rm_next_req", last_req, RPC);
        wait_pop(1, 20);
        check_eq("rm_first_pc", last_pop_pc, RPC);
    endtask

    task automatic test_random();
        bit          r;
        logic [63:0] a;
        do_reset();
        lat = 1;
        for (int i = 0; i < 2000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
            r = ($urandom_range(0, 24) == 0);
            a = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            tick(r, a);
        end
        tests++;
        if (npop < 150) begin
            fails++;
            $display("FAIL random_progress: got %0d pops want >= 150", npop);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
